oci_trace_capture: RTL and testbench

- Parametrised successor to the CPU OCI test-bench monitor. Captures data-cache trace (DCT) words and their byte counts into a bounded FIFO while a test runs.
- Tracks the test-ending/test-has-ended lifecycle with a small state machine and exposes the captured trace through a 1-cycle-latency read port.
- Instantiated alongside each CPU's OCI block. Drop and overflow status make trace loss visible instead of silent.

---
 rtl/oci_trace_capture.sv | 113 +++++++++++
 tb/tb_oci_trace_capture.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/oci_trace_capture.sv
// OCI trace capture: buffers DCT words with byte counts in a bounded FIFO
// and tracks the test-ending lifecycle. Trace loss is reported through overflow/drop_count.
module oci_trace_capture #(
  parameter int DATA_W  = 30,
  parameter int COUNT_W = 4,
  parameter int DEPTH   = 16,
  parameter int DROP_W  = 8,
  localparam int PTR_W  = $clog2(DEPTH),
  localparam int LVL_W  = $clog2(DEPTH) + 1,
  localparam int ENT_W  = COUNT_W + DATA_W
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               arm,
  input  logic               dct_valid,
  input  logic [DATA_W-1:0]  dct_buffer,
  input  logic [COUNT_W-1:0] dct_count,
  input  logic               test_ending,
  input  logic               test_has_ended,
  input  logic               rd_req,
  output logic               rd_valid,
  output logic [ENT_W-1:0]   rd_data,
  output logic [LVL_W-1:0]   fifo_level,
  output logic               overflow,
  output logic [DROP_W-1:0]  drop_count,
  output logic [1:0]         state,
  output logic               done
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    ENDING = 2'd2,
    ENDED  = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [ENT_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             full, empty;
  logic             wr_attempt, wr_accept, rd_accept, drop;

  assign full  = (fifo_level == LVL_W'(DEPTH));
  assign empty = (fifo_level == '0);

  // Capture is gated on the registered state, so a sample coinciding with
  // the rising edge of test_ending is still written.
  assign wr_attempt = (state_q == ARMED) && dct_valid && (dct_count != '0);
  assign rd_accept  = rd_req && !empty;
  assign wr_accept  = wr_attempt && (!full || rd_accept);
  assign drop       = wr_attempt && full && !rd_accept;

  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (arm) state_d = ARMED;
      ARMED: begin
        if (test_has_ended)   state_d = ENDED;
        else if (test_ending) state_d = ENDING;
      end
      ENDING:  if (test_has_ended) state_d = ENDED;
      ENDED:   state_d = ENDED;
      default: state_d = IDLE;
    endcase
  end

  // Storage needs no reset; validity is tracked by the pointers and level.
  always_ff @(posedge clk) begin
    if (wr_accept) mem[wr_ptr] <= {dct_count, dct_buffer};
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      rd_valid   <= 1'b0;
      rd_data    <= '0;
    end else begin
      rd_valid <= rd_accept;
      if (wr_accept) wr_ptr <= wr_ptr + 1'b1;
      if (rd_accept) begin
        rd_ptr  <= rd_ptr + 1'b1;
        rd_data <= mem[rd_ptr];
      end
      case ({wr_accept, rd_accept})
        2'b10:   fifo_level <= fifo_level + 1'b1;
        2'b01:   fifo_level <= fifo_level - 1'b1;
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (drop_count != {DROP_W{1'b1}}) drop_count <= drop_count + 1'b1;
    end
  end

  assign state = state_q;
  assign done  = (state_q == ENDED) && empty;

endmodule

// File: tb/tb_oci_trace_capture.sv
// Directed self-checking bench for oci_trace_capture with default parameters.
module tb_oci_trace_capture;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        arm, dct_valid, test_ending, test_has_ended, rd_req;
  logic [29:0] dct_buffer;
  logic [3:0]  dct_count;
  logic        rd_valid, overflow, done;
  logic [33:0] rd_data;
  logic [4:0]  fifo_level;
  logic [7:0]  drop_count;
  logic [1:0]  state;

  int checks = 0;
  int failures = 0;

  oci_trace_capture dut (
    .clk(clk), .reset_n(reset_n), .arm(arm), .dct_valid(dct_valid),
    .dct_buffer(dct_buffer), .dct_count(dct_count), .test_ending(test_ending),
    .test_has_ended(test_has_ended), .rd_req(rd_req), .rd_valid(rd_valid),
    .rd_data(rd_data), .fifo_level(fifo_level), .overflow(overflow),
    .drop_count(drop_count), .state(state), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [33:0] ent(input logic [3:0] c, input logic [29:0] b);
    return {c, b};
  endfunction

  // Drive one cycle of inputs, then advance past the next rising edge.
  task automatic applyStimulus(input logic a, input logic v, input logic [29:0] b,
                               input logic [3:0] c, input logic te, input logic the,
                               input logic rr);
    arm = a; dct_valid = v; dct_buffer = b; dct_count = c;
    test_ending = te; test_has_ended = the; rd_req = rr;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic doReset();
    reset_n = 1'b0;
    applyStimulus(0, 0, '0, '0, 0, 0, 0);
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0;
    arm = 0; dct_valid = 0; dct_buffer = '0; dct_count = '0;
    test_ending = 0; test_has_ended = 0; rd_req = 0;

    // 1. reset and idle
    applyStimulus(0, 0, '0, '0, 0, 0, 0);
    applyStimulus(0, 0, '0, '0, 0, 0, 0);
    reset_n = 1'b1;
    applyStimulus(0, 1, 30'h1234567, 4'd4, 0, 0, 0);
    checkOutput("idle_level", fifo_level, 0);
    checkOutput("idle_state", state, 0);
    checkOutput("idle_ovf", overflow, 0);
    checkOutput("idle_drop", drop_count, 0);
    checkOutput("idle_rdv", rd_valid, 0);
    checkOutput("idle_rdata", rd_data, 0);
    checkOutput("idle_done", done, 0);

    // 2. capture and readback
    applyStimulus(1, 0, '0, '0, 0, 0, 0);
    checkOutput("arm_state", state, 1);
    applyStimulus(0, 1, 30'hA, 4'd1, 0, 0, 0);
    applyStimulus(0, 1, 30'hB, 4'd2, 0, 0, 0);
    applyStimulus(0, 1, 30'hC, 4'd3, 0, 0, 0);
    applyStimulus(0, 1, 30'hD, 4'd0, 0, 0, 0);
    checkOutput("cap_level", fifo_level, 3);
    applyStimulus(0, 0, '0, '0, 0, 0, 1);
    checkOutput("cap_rdv1", rd_valid, 1);
    checkOutput("cap_rd1", rd_data, ent(1, 30'hA));
    applyStimulus(0, 0, '0, '0, 0, 0, 0);
    checkOutput("cap_rdv1_off", rd_valid, 0);
    applyStimulus(0, 0, '0, '0, 0, 0, 1);
    checkOutput("cap_rd2", rd_data, ent(2, 30'hB));
    applyStimulus(0, 0, '0, '0, 0, 0, 0);
    checkOutput("cap_rdv2_off", rd_valid, 0);
    applyStimulus(0, 0, '0, '0, 0, 0, 1);
    checkOutput("cap_rdv3", rd_valid, 1);
    checkOutput("cap_rd3", rd_data, ent(3, 30'hC));
    checkOutput("cap_level0", fifo_level, 0);
    applyStimulus(0, 0, '0, '0, 0, 0, 1);
    checkOutput("empty_rdv", rd_valid, 0);
    checkOutput("empty_hold", rd_data, ent(3, 30'hC));
    checkOutput("cap_drop", drop_count, 0);
    checkOutput("cap_ovf", overflow, 0);

    // 3. overflow and saturation
    for (int i = 0; i < 21; i++) applyStimulus(0, 1, 30'(i), 4'd5, 0, 0, 0);
    checkOutput("ovf_level", fifo_level, 16);
    checkOutput("ovf_flag", overflow, 1);
    checkOutput("ovf_drop", drop_count, 5);
    for (int i = 0; i < 16; i++) begin
      applyStimulus(0, 0, '0, '0, 0, 0, 1);
      checkOutput("ovf_rd", rd_data, ent(5, 30'(i)));
    end
    checkOutput("ovf_drained", fifo_level, 0);
    for (int i = 0; i < 300; i++) applyStimulus(0, 1, 30'(i), 4'd5, 0, 0, 0);
    checkOutput("sat_drop", drop_count, 255);
    checkOutput("sat_level", fifo_level, 16);

    // 4. full with simultaneous read and write
    doReset();
    applyStimulus(1, 0, '0, '0, 0, 0, 0);
    for (int i = 0; i < 16; i++) applyStimulus(0, 1, 30'h100 + 30'(i), 4'd7, 0, 0, 0);
    checkOutput("full_level", fifo_level, 16);
    checkOutput("full_ovf0", overflow, 0);
    applyStimulus(0, 1, 30'h3FF, 4'd2, 0, 0, 1);
    checkOutput("simul_rdv", rd_valid, 1);
    checkOutput("simul_rd", rd_data, ent(7, 30'h100));
    checkOutput("simul_level", fifo_level, 16);
    checkOutput("simul_ovf", overflow, 0);
    checkOutput("simul_drop", drop_count, 0);
    for (int i = 1; i < 16; i++) begin
      applyStimulus(0, 0, '0, '0, 0, 0, 1);
      checkOutput("full_rd", rd_data, ent(7, 30'h100 + 30'(i)));
    end
    applyStimulus(0, 0, '0, '0, 0, 0, 1);
    checkOutput("full_last", rd_data, ent(2, 30'h3FF));

    // 5. lifecycle
    doReset();
    applyStimulus(1, 0, '0, '0, 0, 0, 0);
    applyStimulus(0, 1, 30'h51, 4'd1, 0, 0, 0);
    applyStimulus(0, 1, 30'h52, 4'd1, 0, 0, 0);
    applyStimulus(0, 1, 30'h53, 4'd1, 1, 0, 0);
    checkOutput("life_level", fifo_level, 3);
    checkOutput("life_ending", state, 2);
    applyStimulus(0, 1, 30'h54, 4'd1, 1, 0, 0);
    checkOutput("life_ignored", fifo_level, 3);
    applyStimulus(0, 0, '0, '0, 1, 1, 0);
    checkOutput("life_ended", state, 3);
    checkOutput("life_done0", done, 0);
    applyStimulus(1, 0, '0, '0, 0, 1, 1);
    checkOutput("life_arm_ign", state, 3);
    checkOutput("life_rd1", rd_data, ent(1, 30'h51));
    applyStimulus(0, 0, '0, '0, 0, 1, 1);
    checkOutput("life_rd2", rd_data, ent(1, 30'h52));
    checkOutput("life_done_mid", done, 0);
    applyStimulus(0, 0, '0, '0, 0, 1, 1);
    checkOutput("life_rd3", rd_data, ent(1, 30'h53));
    checkOutput("life_done1", done, 1);

    // 6. reset mid-operation
    doReset();
    applyStimulus(1, 0, '0, '0, 0, 0, 0);
    for (int i = 0; i < 20; i++) applyStimulus(0, 1, 30'(i), 4'd3, 0, 0, 0);
    for (int i = 0; i < 9; i++) applyStimulus(0, 0, '0, '0, 0, 0, 1);
    applyStimulus(0, 0, '0, '0, 1, 0, 0);
    checkOutput("mid_level", fifo_level, 7);
    checkOutput("mid_state", state, 2);
    checkOutput("mid_ovf", overflow, 1);
    checkOutput("mid_drop", drop_count, 4);
    reset_n = 1'b0;
    applyStimulus(0, 1, 30'h77, 4'd3, 1, 0, 1);
    checkOutput("rst_level", fifo_level, 0);
    checkOutput("rst_state", state, 0);
    checkOutput("rst_ovf", overflow, 0);
    checkOutput("rst_drop", drop_count, 0);
    checkOutput("rst_rdv", rd_valid, 0);
    checkOutput("rst_rdata", rd_data, 0);
    reset_n = 1'b1;
    applyStimulus(0, 0, '0, '0, 0, 0, 1);
    checkOutput("post_rdv", rd_valid, 0);
    checkOutput("post_level", fifo_level, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
